// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: core port, loader port and the shared memory port.
// The arbiter uses the slave modport; requesters and memory use master.
`ifndef ADDR_W
`define ADDR_W 16
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

interface mem_port_arbiter_if;
   logic               c_req;
   logic               c_we;
   logic [`ADDR_W-1:0] c_addr;
   logic [`WORD_W-1:0] c_wdata;
   logic               c_gnt;
   logic               c_rvalid;
   logic [`WORD_W-1:0] c_rdata;

   logic               l_req;
   logic               l_we;
   logic [`ADDR_W-1:0] l_addr;
   logic [`WORD_W-1:0] l_wdata;
   logic               l_gnt;
   logic               l_rvalid;
   logic [`WORD_W-1:0] l_rdata;

   logic [`ADDR_W-1:0] m_addr;
   logic [`WORD_W-1:0] m_wdata;
   logic               m_we;
   logic [`WORD_W-1:0] m_rdata;

   logic               stall_req;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_gnt, c_rvalid, c_rdata,
      input  l_req, l_we, l_addr, l_wdata,
      output l_gnt, l_rvalid, l_rdata,
      output m_addr, m_wdata, m_we,
      input  m_rdata,
      output stall_req
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      output l_req, l_we, l_addr, l_wdata,
      input  l_gnt, l_rvalid, l_rdata,
      input  m_addr, m_wdata, m_we,
      output m_rdata,
      input  stall_req
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port data memory between the core and the loader, returning tagged read data.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise fixed core priority with MAX_WAIT override.
`ifndef ADDR_W
`define ADDR_W 16
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

module mem_port_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int MAX_WAIT     = 15
) (
   input logic               clk,
   input logic               rstn,
   mem_port_arbiter_if.slave bus
);

   logic                     gnt_c;
   logic                     gnt_l;
   logic                     loader_wins;
   logic                     rd_push;
   logic [`ADDR_W-1:0]       m_addr_q;
   logic [`WORD_W-1:0]       m_wdata_q;
   logic                     m_we_q;
   logic [READ_LATENCY:0]    pipe_valid;
   logic [READ_LATENCY:0]    pipe_id;
   logic                     ret_c;
   logic                     ret_l;

`ifdef ARB_ROUND_ROBIN_EN
   // last_owner: 1 = loader, 0 = core; resetting to loader hands the first tie to the core
   logic last_owner;

   assign loader_wins = ~last_owner;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_owner <= 1'b1;
      end else if (gnt_c || gnt_l) begin
         last_owner <= gnt_l;
      end
   end
`else
   localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

   logic [7:0] wait_cnt;

   assign loader_wins = (wait_cnt == MaxWait);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wait_cnt <= 8'd0;
      end else if (!bus.l_req || gnt_l) begin
         wait_cnt <= 8'd0;
      end else if (wait_cnt < MaxWait) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`endif

   always_comb begin
      gnt_c = 1'b0;
      gnt_l = 1'b0;
      if (bus.c_req && bus.l_req) begin
         gnt_l = loader_wins;
         gnt_c = ~loader_wins;
      end else begin
         gnt_c = bus.c_req;
         gnt_l = bus.l_req;
      end
   end

   assign rd_push = (gnt_c && !bus.c_we) || (gnt_l && !bus.l_we);

   // Address and data hold when idle so the memory sees a stable bus
   always_ff @(posedge clk) begin
      if (!rstn) begin
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_we_q    <= 1'b0;
      end else if (gnt_l) begin
         m_addr_q  <= bus.l_addr;
         m_wdata_q <= bus.l_wdata;
         m_we_q    <= bus.l_we;
      end else if (gnt_c) begin
         m_addr_q  <= bus.c_addr;
         m_wdata_q <= bus.c_wdata;
         m_we_q    <= bus.c_we;
      end else begin
         m_we_q    <= 1'b0;
      end
   end

   // Stage k is visible k+1 cycles after the grant; the last stage lines up with m_rdata
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pipe_valid <= '0;
         pipe_id    <= '0;
      end else begin
         pipe_valid <= {pipe_valid[READ_LATENCY-1:0], rd_push};
         pipe_id    <= {pipe_id[READ_LATENCY-1:0], gnt_l};
      end
   end

   assign ret_c = pipe_valid[READ_LATENCY] && !pipe_id[READ_LATENCY];
   assign ret_l = pipe_valid[READ_LATENCY] &&  pipe_id[READ_LATENCY];

   assign bus.c_gnt     = gnt_c;
   assign bus.l_gnt     = gnt_l;
   assign bus.stall_req = bus.c_req && !gnt_c;
   assign bus.m_addr    = m_addr_q;
   assign bus.m_wdata   = m_wdata_q;
   assign bus.m_we      = m_we_q;
   assign bus.c_rvalid  = ret_c;
   assign bus.l_rvalid  = ret_l;
   assign bus.c_rdata   = ret_c ? bus.m_rdata : '0;
   assign bus.l_rdata   = ret_l ? bus.m_rdata : '0;

endmodule
